// File: rtl/raid_pkg.sv
// raid_pkg: shared FSM states, card select codes and stripe role table
package raid_pkg;
  typedef enum logic [2:0] {IDLE, RD_D0, RD_D1, RD_P, CHECK, DONE, ERROR} state_t;
  localparam logic [1:0] CARD_NONE = 2'b00;
  localparam logic [1:0] CARD1 = 2'b01;
  localparam logic [1:0] CARD2 = 2'b10;
  localparam logic [1:0] CARD3 = 2'b11;
  typedef struct packed {
    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] p;
  } roles_t;
  // indexed by stripe_num mod 3: parity rotates across the three cards
  localparam roles_t ROLE_TABLE [3] = '{
    '{CARD1, CARD2, CARD3},
    '{CARD1, CARD3, CARD2},
    '{CARD2, CARD3, CARD1}
  };
  // select code to one-hot request bit; code 00 requests nothing
  function automatic logic [2:0] card_bit(input logic [1:0] c);
    return (c == CARD_NONE) ? 3'b000 : 3'b001 << (c - 2'd1);
  endfunction
endpackage

// File: rtl/stripe_role_map.sv
// stripe_role_map: combinational stripe index to data/parity card roles
module stripe_role_map
  import raid_pkg::*;
(
  input  logic [7:0] stripe_num,
  output logic [1:0] d0,
  output logic [1:0] d1,
  output logic [1:0] p
);
  logic [1:0] r;
  assign r = 2'(stripe_num % 8'd3);
  assign {d0, d1, p} = (r == 2'd0) ? ROLE_TABLE[0] : (r == 2'd1) ? ROLE_TABLE[1] : ROLE_TABLE[2];
endmodule

// File: rtl/sd_stripe_read_ctrl.sv
// sd_stripe_read_ctrl: reads D0, D1, P per word from three SD cards, stores data, checks parity
module sd_stripe_read_ctrl
  import raid_pkg::*;
#(
  parameter int WORDS = 128,
  parameter int TIMEOUT = 255,
  localparam int AW = $clog2(2 * WORDS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [7:0]    stripe_num,
  input  logic [2:0]    sd_ack,
  input  logic [31:0]   data_in,
  output logic [2:0]    sd_req,
  output logic [1:0]    selectid,
  output logic [1:0]    sram1sd,
  output logic [1:0]    sram2sd,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  output logic          busy,
  output logic          done,
  output logic          parity_err,
  output logic          timeout_err
);
  localparam int IW = AW - 1;
  state_t state;
  logic [1:0] md0, md1, mp, d0_r, d1_r, p_r, nxt_sel;
  logic [IW-1:0] idx;
  logic [31:0] acc;
  logic [7:0] cnt;
  logic ack, tmo;

  stripe_role_map u_role (.stripe_num(stripe_num), .d0(md0), .d1(md1), .p(mp));

  assign sram1sd = CARD1;
  assign sram2sd = CARD2;
  // sd_req only ever holds the current card's bit, so this masks acks from other cards
  assign ack = |(sd_ack & sd_req);
  assign tmo = cnt == 8'(TIMEOUT - 1);
  assign nxt_sel = (state == RD_D0) ? d1_r : (state == RD_D1) ? p_r : CARD_NONE;

  // stripe read sequencer; all outputs registered and updated on state entry
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      d0_r <= CARD_NONE;
      d1_r <= CARD_NONE;
      p_r <= CARD_NONE;
      idx <= '0;
      acc <= '0;
      cnt <= '0;
      sd_req <= '0;
      selectid <= CARD_NONE;
      sram_wen <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      parity_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          d0_r <= md0;
          d1_r <= md1;
          p_r <= mp;
          parity_err <= 1'b0;
          timeout_err <= 1'b0;
          idx <= '0;
          acc <= '0;
          cnt <= '0;
          busy <= 1'b1;
          sd_req <= card_bit(md0);
          selectid <= md0;
          state <= RD_D0;
        end
        RD_D0, RD_D1, RD_P: if (ack) begin
          sram_wdata <= data_in;
          acc <= acc ^ data_in;
          cnt <= '0;
          sram_wen <= state != RD_P;
          sram_addr <= (state == RD_P) ? sram_addr : {state == RD_D1, idx};
          sd_req <= card_bit(nxt_sel);
          selectid <= nxt_sel;
          state <= (state == RD_D0) ? RD_D1 : (state == RD_D1) ? RD_P : CHECK;
        end else if (tmo) begin
          timeout_err <= 1'b1;
          sd_req <= '0;
          selectid <= CARD_NONE;
          done <= 1'b1;
          state <= ERROR;
        end else begin
          cnt <= cnt + 8'd1;
        end
        CHECK: begin
          parity_err <= parity_err | (|acc);
          acc <= '0;
          idx <= idx + 1'b1;
          if (idx == IW'(WORDS - 1)) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            sd_req <= card_bit(d0_r);
            selectid <= d0_r;
            state <= RD_D0;
          end
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sd_stripe_read_ctrl.sv
// tb_sd_stripe_read_ctrl: card responder model with write scoreboard
module tb_sd_stripe_read_ctrl;
  localparam int WORDS = 4;
  localparam int TIMEOUT = 5;

  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0;
  logic [7:0] stripe_num = 8'd0;
  logic [2:0] sd_ack, real_ack = 3'b000, junk = 3'b000;
  logic [31:0] data_in, rdata = 32'hDEAD_BEEF;
  logic [2:0] sd_req;
  logic [1:0] selectid, sram1sd, sram2sd;
  logic sram_wen, busy, done, parity_err, timeout_err;
  logic [2:0] sram_addr;
  logic [31:0] sram_wdata;

  int n_chk = 0, n_bad = 0;
  int cyc = 0, last_req_cyc = 0, step = 0, nwr = 0;
  logic [2:0] prev_req = 3'b000, en = 3'b111;
  logic [1:0] role [0:2];
  logic [31:0] dat [1:3][0:3];
  int wcnt [1:3];
  logic [34:0] exp_q [$];

  assign sd_ack = real_ack | junk;
  assign data_in = rdata;

  sd_stripe_read_ctrl #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .stripe_num(stripe_num),
    .sd_ack(sd_ack), .data_in(data_in), .sd_req(sd_req), .selectid(selectid),
    .sram1sd(sram1sd), .sram2sd(sram2sd), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .busy(busy), .done(done), .parity_err(parity_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // card model: checks request order, acks one cycle after a request appears
  always @(negedge clk) begin
    int code;
    cyc++;
    real_ack = 3'b000;
    rdata = 32'hDEAD_BEEF;
    if (sd_req != 3'b000 && sd_req != prev_req) begin
      chk("selectid", selectid, role[step % 3]);
      chk("sd_req", sd_req, 3'b001 << (role[step % 3] - 2'd1));
      step++;
      last_req_cyc = cyc;
    end else if (sd_req != 3'b000 && sd_req == prev_req) begin
      code = sd_req[0] ? 1 : sd_req[1] ? 2 : 3;
      if (en[code-1] && wcnt[code] < WORDS) begin
        real_ack = sd_req;
        rdata = dat[code][wcnt[code]];
        if (code == int'(role[0])) exp_q.push_back({3'(wcnt[code]), rdata});
        else if (code == int'(role[1])) exp_q.push_back({3'(WORDS + wcnt[code]), rdata});
        wcnt[code]++;
      end
    end
    prev_req = sd_req;
  end

  // write monitor: every SRAM write must match the oldest expected one
  always @(negedge clk) begin
    logic [34:0] e;
    if (n_rst && sram_wen) begin
      nwr++;
      chk("wr_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", sram_addr, e[34:32]);
        chk("wr_data", sram_wdata, e[31:0]);
      end
    end
  end

  task automatic setup(input logic [7:0] sn, input logic [2:0] en_i, input int cw);
    logic [31:0] a, b;
    case (sn % 3)
      0: role = '{2'd1, 2'd2, 2'd3};
      1: role = '{2'd1, 2'd3, 2'd2};
      default: role = '{2'd2, 2'd3, 2'd1};
    endcase
    for (int w = 0; w < WORDS; w++) begin
      a = $urandom;
      b = $urandom;
      dat[role[0]][w] = a;
      dat[role[1]][w] = b;
      dat[role[2]][w] = a ^ b ^ ((w == cw) ? 32'h1 : 32'h0);
    end
    for (int k = 1; k <= 3; k++) wcnt[k] = 0;
    step = 0;
    en = en_i;
    exp_q.delete();
    @(negedge clk);
    stripe_num = sn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_run", busy, 1);
  endtask

  task automatic run(input string tag, input logic [7:0] sn, input logic [2:0] en_i, input int cw,
                     input logic exp_par, input logic exp_to, input int exp_wr);
    int wr0;
    logic got;
    wr0 = nwr;
    got = 1'b0;
    setup(sn, en_i, cw);
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      got = done;
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_parity_err"}, parity_err, exp_par);
    chk({tag, "_timeout_err"}, timeout_err, exp_to);
    chk({tag, "_writes"}, nwr - wr0, exp_wr);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    if (exp_to) begin
      chk({tag, "_to_latency"}, cyc - last_req_cyc, TIMEOUT);
      chk({tag, "_to_req"}, sd_req, 0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sd_req"}, sd_req, 0);
    chk({tag, "_selectid"}, selectid, 0);
    chk({tag, "_wen"}, sram_wen, 0);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_wdata"}, sram_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_sram1sd"}, sram1sd, 2'b01);
    chk({tag, "_sram2sd"}, sram2sd, 2'b10);
  endtask

  initial begin
    int wr0;
    logic hit;
    role = '{2'd1, 2'd2, 2'd3};
    for (int k = 1; k <= 3; k++) wcnt[k] = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    n_rst = 1'b1;
    run("s0", 8'd0, 3'b111, -1, 1'b0, 1'b0, 8);
    run("s4", 8'd4, 3'b111, -1, 1'b0, 1'b0, 8);
    run("s8_par", 8'd8, 3'b111, 2, 1'b1, 1'b0, 8);
    run("tmo", 8'd0, 3'b101, -1, 1'b0, 1'b1, 1);
    fork
      run("ignore", 8'd0, 3'b111, -1, 1'b0, 1'b0, 8);
      begin
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
          @(negedge clk);
          #1;
          hit = (sd_req == 3'b010) && (step == 2);
        end
        chk("ignore_found_d1", hit, 1);
        start = 1'b1;
        stripe_num = 8'd1;
        junk = 3'b100;
        @(negedge clk);
        start = 1'b0;
        junk = 3'b000;
      end
    join
    run("after_err", 8'd5, 3'b111, -1, 1'b0, 1'b0, 8);
    setup(8'd0, 3'b111, -1);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = (sd_req == 3'b100) && (step == 6);
    end
    chk("rst_found_p", hit, 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    wr0 = nwr;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_writes", nwr - wr0, 0);
    chk("midrst_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end
endmodule
